// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues word requests to instruction memory and buffers
// returned words for decode. Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
module fetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 2;

    logic [31:0]      fetch_pc;
    logic [31:0]      slot_pc    [DEPTH];
    logic [31:0]      slot_pc4   [DEPTH];
    logic [31:0]      slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    drop;
    logic             run;
    logic             faulted;

    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    fill_idx;
    logic [PW-1:0]    occupancy;
    logic [PW-1:0]    live_inflight;
    logic [CW-1:0]    credit_used;
    logic [CW-1:0]    drop_on_flush;
    logic [31:0]      target_aligned;
    logic [31:0]      pc_next;
    logic             accept;
    logic             deq;
    logic             fill;
    logic             discard;

    assign rd_idx        = rd_ptr[AW-1:0];
    assign wr_idx        = wr_ptr[AW-1:0];
    assign fill_idx      = fill_ptr[AW-1:0];
    assign occupancy     = wr_ptr - rd_ptr;
    assign live_inflight = wr_ptr - fill_ptr;
    assign credit_used   = CW'(occupancy) + CW'(drop);
    assign target_aligned = redirect_target & 32'hFFFF_FFFC;
    assign pc_next       = fetch_pc + 32'd4;

    // Everything still outstanding becomes stale; a response landing this cycle is one of them.
    assign drop_on_flush = CW'(drop) + CW'(live_inflight) - CW'(imem_rsp_valid);

    // Credit depends only on registered state and the redirect input.
    assign imem_req_valid = rst_n && run && !redirect_valid && !faulted
                            && (credit_used < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign accept  = imem_req_valid && imem_req_ready;
    assign deq     = dec_valid && dec_ready && !redirect_valid;
    assign fill    = imem_rsp_valid && !redirect_valid && (drop == '0) && (live_inflight != '0);
    assign discard = imem_rsp_valid && !redirect_valid && (drop != '0);

    assign dec_valid    = slot_filled[rd_idx];
    assign dec_instr    = slot_instr[rd_idx];
    assign dec_pc       = slot_pc[rd_idx];
    assign dec_pc_plus4 = slot_pc4[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            drop        <= '0;
            slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_pc4[i]   <= '0;
                slot_instr[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                fetch_pc    <= target_aligned;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                fill_ptr    <= '0;
                slot_filled <= '0;
                drop        <= PW'(drop_on_flush);
            end else begin
                if (accept) begin
                    fetch_pc         <= pc_next;
                    slot_pc[wr_idx]  <= fetch_pc;
                    slot_pc4[wr_idx] <= pc_next;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (fill) begin
                    slot_instr[fill_idx]  <= imem_rsp_data;
                    slot_filled[fill_idx] <= 1'b1;
                    fill_ptr              <= fill_ptr + PW'(1);
                end else if (discard) begin
                    drop <= drop - PW'(1);
                end
                // A filled head is never the fill target, so these never collide.
                if (deq) begin
                    slot_filled[rd_idx] <= 1'b0;
                    rd_ptr              <= rd_ptr + PW'(1);
                end
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            faulted <= 1'b0;
        end else if (redirect_valid) begin
            faulted <= (redirect_target[1:0] != 2'b00);
        end
    end
`else
    assign faulted = 1'b0;
`endif

    assign fetch_fault = faulted;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against an in-order
// variable-latency instruction memory and a sequential-stream reference model.
`timescale 1ns/1ps
module tb_fetch_stage;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_fault(fetch_fault)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit rand_ready = 1'b0;
    int deq_count = 0;
    int acc_count = 0;

    // Expected decode stream: sequential word addresses from the last restart point.
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail = 32'h0;
    bit          stream_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, req);
    endtask

    task automatic top_up();
        while (stream_on && exp_q.size() < 64) begin
            exp_q.push_back(exp_tail);
            exp_tail = exp_tail + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_tail  = pc;
        stream_on = 1'b1;
        top_up();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        top_up();
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
`ifdef FETCH_ALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            exp_q.delete();
            stream_on = 1'b0;
        end else begin
            restart_stream(t);
        end
`else
        restart_stream(t & 32'hFFFF_FFFC);
`endif
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_dec_valid(input int bound, input logic [31:0] exp_pc, input string name);
        int n = 0;
        while (!dec_valid && n < bound) begin
            step();
            n++;
        end
        if (!dec_valid) begin
            checks++;
            $display("FAIL %s: dec_valid got 0 expected 1 within %0d cycles", name, bound);
        end else begin
            check(name, dec_pc, exp_pc);
        end
    endtask

    // Instruction memory: in-order responses, data = addr ^ XOR_KEY, latency lat_min..lat_max.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    always @(posedge clk) begin : mem_model
        logic        acc;
        logic        took;
        logic        r;
        logic [31:0] a;
        int          d;
        acc  = imem_req_valid && imem_req_ready;
        took = imem_rsp_valid;
        r    = rst_n;
        a    = imem_req_addr;
        cyc++;
        if (!r) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (took && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (acc) begin
                d = int'($urandom_range(lat_max, lat_min));
                mq_addr.push_back(a);
                mq_due.push_back(cyc + d - 1);
                acc_count++;
            end
        end
        #1;
        if (r && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr[0] ^ XOR_KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
    end

    // Monitor: pops the expected stream on every real dequeue and checks side rules.
    bit          stalled = 1'b0;
    logic [31:0] st_pc;
    logic [31:0] st_instr;
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (redirect_valid) check("req_low_on_redirect", 32'(imem_req_valid), 0);
            if (imem_req_valid) check("req_addr_aligned", 32'(imem_req_addr[1:0]), 0);
            if (mq_addr.size() > DEPTH) check("inflight_cap", mq_addr.size(), DEPTH);
            if (stalled && !redirect_valid) begin
                check("stall_valid", 32'(dec_valid), 1);
                check("stall_pc", dec_pc, st_pc);
                check("stall_instr", dec_instr, st_instr);
            end
            if (dec_valid && dec_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL dec_unexpected: got pc %08h expected no output", dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_pc", dec_pc, e);
                    check("dec_instr", dec_instr, e ^ XOR_KEY);
                    check("dec_pc_plus4", dec_pc_plus4, e + 32'd4);
                end
                deq_count++;
            end
            stalled  = dec_valid && !dec_ready && !redirect_valid;
            st_pc    = dec_pc;
            st_instr = dec_instr;
        end
    end

    initial begin : stimulus
        int base;
        int n;
        logic [31:0] t;

        // Reset values and release timing.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_req_valid", 32'(imem_req_valid), 0);
            check("rst_dec_valid", 32'(dec_valid), 0);
            check("rst_fault", 32'(fetch_fault), 0);
            check("rst_dec_instr", dec_instr, 0);
            check("rst_dec_pc", dec_pc, 0);
            check("rst_dec_pc_plus4", dec_pc_plus4, 0);
            check("rst_req_addr", imem_req_addr, RESET_PC);
        end
        rst_n = 1'b1;
        restart_stream(RESET_PC);
        #1;
        check("first_cycle_req_low", 32'(imem_req_valid), 0);
        step();
        check("second_cycle_req", 32'(imem_req_valid), 1);
        check("second_cycle_addr", imem_req_addr, RESET_PC);
        step();
        check("fill_latency_not_yet", 32'(dec_valid), 0);
        step();
        check("fill_latency_valid", 32'(dec_valid), 1);
        check("fill_latency_pc", dec_pc, RESET_PC);

        // Streaming throughput with 1-cycle memory.
        for (int i = 0; i < 20; i++) step();
        base = deq_count;
        for (int i = 0; i < 10; i++) step();
        check("throughput", deq_count - base, 10);

        // Decode stall: credit limits the queue, then drain in order.
        dec_ready = 1'b0;
        base = acc_count;
        for (int i = 0; i < 10; i++) step();
        check("stall_accepts_le_depth", 32'(acc_count - base <= DEPTH), 1);
        check("stall_req_low_full", 32'(imem_req_valid), 0);
        check("stall_head_valid", 32'(dec_valid), 1);
        dec_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();

        // 3-cycle memory, redirect with three requests outstanding.
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (mq_addr.size() != 3 && n < 30) begin
            step();
            n++;
        end
        check("three_inflight_reached", mq_addr.size(), 3);
        redirect(32'h0000_0100);
        wait_dec_valid(20, 32'h0000_0100, "redirect_lat3_first_pc");
        for (int i = 0; i < 15; i++) step();

        // Redirect coinciding with a response and a dequeue, 1-cycle memory.
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10; i++) step();
        check("coincide_rsp_present", 32'(imem_rsp_valid), 1);
        check("coincide_dec_present", 32'(dec_valid), 1);
        redirect(32'h0000_0400);
        check("redir_n1_empty", 32'(dec_valid), 0);
        check("redir_n1_req_addr", imem_req_addr, 32'h0000_0400);
        step();
        check("redir_n2_empty", 32'(dec_valid), 0);
        step();
        check("redir_n3_valid", 32'(dec_valid), 1);
        check("redir_n3_pc", dec_pc, 32'h0000_0400);
        for (int i = 0; i < 8; i++) step();

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFF8);
        wait_dec_valid(10, 32'hFFFF_FFF8, "wrap_first_pc");
        for (int i = 0; i < 10; i++) step();

        // Misaligned redirect.
        redirect(32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
        check("fault_set", 32'(fetch_fault), 1);
        for (int i = 0; i < 8; i++) begin
            check("fault_no_req", 32'(imem_req_valid), 0);
            step();
        end
        check("fault_queue_empty", 32'(dec_valid), 0);
        check("fault_sticky", 32'(fetch_fault), 1);
        redirect(32'h0000_0200);
        check("fault_cleared", 32'(fetch_fault), 0);
        wait_dec_valid(10, 32'h0000_0200, "fault_resume_pc");
`else
        check("no_fault_default", 32'(fetch_fault), 0);
        wait_dec_valid(10, 32'h0000_0100, "misaligned_forced_pc");
        for (int i = 0; i < 6; i++) step();
        redirect(32'h0000_0200);
        wait_dec_valid(10, 32'h0000_0200, "resume_pc");
`endif
        for (int i = 0; i < 8; i++) step();

        // Randomized traffic with redirects and one mid-run reset.
        lat_min = 1;
        lat_max = 4;
        rand_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            dec_ready = ($urandom_range(3, 0) != 0);
            if (i == 700) begin
                rst_n = 1'b0;
                restart_stream(RESET_PC);
                step();
                rst_n = 1'b1;
                wait_dec_valid(20, RESET_PC, "midrun_reset_pc");
            end else if ($urandom_range(39, 0) == 0) begin
                case ($urandom_range(2, 0))
                    0:       t = 32'h0000_1000;
                    1:       t = 32'hFFFF_FFF0;
                    default: t = $urandom & 32'hFFFF_FFFC;
                endcase
`ifndef FETCH_ALIGN_CHECK_EN
                t = t | 32'($urandom_range(3, 0));
`endif
                redirect(t);
            end else begin
                step();
            end
        end

        // Quiet drain.
        rand_ready = 1'b0;
        lat_min = 1;
        lat_max = 1;
        dec_ready = 1'b1;
        base = deq_count;
        for (int i = 0; i < 40; i++) step();
        check("final_drain_streaming", 32'(deq_count - base >= 30), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time got limit expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the decode/control path. It owns the program counter and issues word requests to instruction memory over a valid/ready request channel with in-order, fixed-or-variable-latency responses. Returned words are buffered in a small prefetch queue and presented to decode with their PC and PC+4. A redirect input (taken branch/jump) flushes the queue and restarts fetch at a new target.

## Interface
- `DEPTH`, 4: prefetch queue entries; also the cap on in-flight plus buffered words (power of two, at least 2).
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, and reset is synchronous and active-low.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  byte address of the requested word; bits [1:0] always 0.
- `imem_rsp_valid`  in  1  response word valid; responses return in request order, at most one per cycle, never before the cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `dec_valid`  out  1  head of queue valid.
- `dec_ready`  in  1  decode consumes the head this cycle.
- `dec_instr`  out  32  instruction at the head.
- `dec_pc`  out  32  address of `dec_instr`.
- `dec_pc_plus4`  out  32  `dec_pc + 4`, modulo 2^32.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_target`  in  32  new fetch address.
- `fetch_fault`  out  1  misaligned redirect target (see Configuration).

## Operation
- State: `fetch_pc`, queue of `DEPTH` entries {pc, instr, filled}, read/write pointers, `inflight` count, `drop` count.
- A slot is reserved at request acceptance and stores the request address. The response fills the oldest unfilled slot.
- Credit rule: `imem_req_valid` = 1 iff occupancy (reserved slots) + `drop` < `DEPTH`, no redirect this cycle, and not faulted.
- On acceptance (`imem_req_valid & imem_req_ready`), `fetch_pc` advances by 4. It wraps from 32'hFFFF_FFFC to 0.
- `dec_valid` = 1 iff the head slot is filled. Dequeue happens on `dec_valid & dec_ready`.
- Redirect handling:
  - All slots are cleared and `drop` is set to the number of requests still outstanding, minus one if a response arrives in that same cycle.
  - `fetch_pc` is set to the target.
  - While `drop` > 0, each response is discarded and `drop` decrements.
- Simultaneous events:
  - Redirect together with a dequeue: the flush wins.
  - Redirect together with a response: the response is discarded.
  - Enqueue and dequeue together on a full queue: both take effect.
- Reset values:
  - `imem_req_valid`, `dec_valid` and `fetch_fault` are 0.
  - `dec_instr`, `dec_pc` and `dec_pc_plus4` are 0.
  - `imem_req_addr` equals `RESET_PC`.
  - `drop` is 0 and the queue is empty.
- Reset asserted mid-operation abandons all in-flight requests with no drop accounting. The memory side is reset in the same cycle.

## Timing
- `imem_req_valid` is low during reset and in the first cycle after `rst_n` rises. The first request issues in the second cycle.
- Response to decode latency is one cycle. A response at edge N makes `dec_valid` high from edge N+1. There is no combinational bypass.
- With 1-cycle memory and `dec_ready` held high, throughput is one instruction per cycle after fill.
- Redirect at cycle N: no request in N. A request to the target issues in N+1. With 1-cycle memory, `dec_valid` is high at N+3 with `dec_pc` = target.
- `dec_*` outputs are stable while `dec_valid & !dec_ready`.
- No combinational path runs from `dec_ready` or `imem_rsp_*` to `imem_req_valid`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_target[1:0] != 0` sets `fetch_fault` the next cycle. The flush happens as normal.
  - `fetch_fault` is sticky, and `imem_req_valid` stays 0 until an aligned redirect or reset clears it.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `redirect_target[1:0]` is forced to 00 silently.
  - `fetch_fault` is tied 0.

## Test plan
- Reset, `RESET_PC`=0, 1-cycle memory returning addr^32'hA5A5_0000, `dec_ready`=1 → `dec_pc` sequence 0,4,8,…, one per cycle after fill, with correct `dec_instr`.
- `dec_ready`=0 for 10 cycles → at most 4 requests accepted, `imem_req_valid` low while full. Releasing `dec_ready` gives in-order drain with no loss or duplicate.
- 3-cycle memory latency, redirect to 32'h100 with 3 requests in flight → the 3 stale responses are dropped, and the first `dec_pc` after the redirect is 32'h100.
- Redirect in the same cycle as a response and a dequeue → nothing from the old stream reaches decode, and the next `dec_pc` is the target.
- `fetch_pc` at 32'hFFFF_FFF8 → sequence FFFF_FFF8, FFFF_FFFC, 0. `dec_pc_plus4` at FFFF_FFFC is 0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 32'h102 → `fetch_fault`=1 and no requests. A later redirect to 32'h200 clears the fault and fetch resumes at 32'h200. Without the macro, the same stimulus fetches at 32'h100.
